// File: rtl/fp_square_result_stage.sv
// Two-entry in-order output buffer behind the floating-point squarer, with
// sticky IEEE exception flags and saturating event counters for software.
module fp_square_result_stage #(
    parameter int sig_width = 23,
    parameter int exp_width = 8,
    parameter int cnt_width = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [sig_width+exp_width:0]   in_z,
    input  logic [7:0]                     in_status,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [sig_width+exp_width:0]   out_z,
    output logic [7:0]                     out_status,
    input  logic                           clr_sticky,
    output logic [5:0]                     sticky,
    output logic [cnt_width-1:0]           cnt_invalid,
    output logic [cnt_width-1:0]           cnt_huge,
    output logic [cnt_width-1:0]           cnt_tiny
);

    localparam logic [cnt_width-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                        state;
    logic [sig_width+exp_width:0]  tail_z;
    logic [7:0]                    tail_status;
    logic                          accept;
    logic                          deliver;

    logic [5:0]                    sticky_base;
    logic [cnt_width-1:0]          inv_base;
    logic [cnt_width-1:0]          huge_base;
    logic [cnt_width-1:0]          tiny_base;
    logic [5:0]                    sticky_nxt;
    logic [cnt_width-1:0]          inv_nxt;
    logic [cnt_width-1:0]          huge_nxt;
    logic [cnt_width-1:0]          tiny_nxt;

    function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] c,
                                                     input logic hit);
        if (hit && !(&c))
            return c + CNT_ONE;
        return c;
    endfunction

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    // Queue stage: head lives directly in the output registers, tail behind it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_z      <= '0;
            out_status <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_z      <= in_z;
                        out_status <= in_status;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        out_z      <= in_z;
                        out_status <= in_status;
                    end else if (accept) begin
                        tail_z      <= in_z;
                        tail_status <= in_status;
                        state       <= FULL;
                    end else if (deliver) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        out_z      <= tail_z;
                        out_status <= tail_status;
                        state      <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // A clear in the same cycle as an accept keeps only the accepted word's flags.
    always_comb begin
        sticky_base = clr_sticky ? 6'd0 : sticky;
        inv_base    = clr_sticky ? '0 : cnt_invalid;
        huge_base   = clr_sticky ? '0 : cnt_huge;
        tiny_base   = clr_sticky ? '0 : cnt_tiny;
        sticky_nxt  = sticky_base | (accept ? in_status[5:0] : 6'd0);
        inv_nxt     = sat_inc(inv_base,  accept & in_status[2]);
        huge_nxt    = sat_inc(huge_base, accept & in_status[4]);
        tiny_nxt    = sat_inc(tiny_base, accept & in_status[3]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky      <= '0;
            cnt_invalid <= '0;
            cnt_huge    <= '0;
            cnt_tiny    <= '0;
        end else begin
            sticky      <= sticky_nxt;
            cnt_invalid <= inv_nxt;
            cnt_huge    <= huge_nxt;
            cnt_tiny    <= tiny_nxt;
        end
    end

endmodule

// File: tb/tb_fp_square_result_stage.sv
// Bench for fp_square_result_stage: directed vector table, hand sequences for
// saturation/clear/reset, then randomized traffic against a queue-based model.
module tb_fp_square_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_z;
    logic [7:0]  in_status;
    logic        out_ready;
    logic        clr_sticky;

    logic        in_ready, out_valid;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic [5:0]  sticky;
    logic [15:0] cnt_invalid, cnt_huge, cnt_tiny;

    logic        in_ready2, out_valid2;
    logic [31:0] out_z2;
    logic [7:0]  out_status2;
    logic [5:0]  sticky2;
    logic [1:0]  cnt_invalid2, cnt_huge2, cnt_tiny2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_square_result_stage #(.sig_width(23), .exp_width(8), .cnt_width(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_z(in_z), .in_status(in_status), .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_status(out_status), .clr_sticky(clr_sticky), .sticky(sticky),
        .cnt_invalid(cnt_invalid), .cnt_huge(cnt_huge), .cnt_tiny(cnt_tiny)
    );

    fp_square_result_stage #(.sig_width(23), .exp_width(8), .cnt_width(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_z(in_z), .in_status(in_status), .out_valid(out_valid2), .out_ready(out_ready),
        .out_z(out_z2), .out_status(out_status2), .clr_sticky(clr_sticky), .sticky(sticky2),
        .cnt_invalid(cnt_invalid2), .cnt_huge(cnt_huge2), .cnt_tiny(cnt_tiny2)
    );

    // Reference model: a FIFO of {status, z} capped at two entries plus flag tallies.
    logic [39:0] q[$];
    logic [5:0]  m_sticky;
    int          m_inv, m_huge, m_tiny;
    int          m_inv2, m_huge2, m_tiny2;

    function automatic int sat(input int c, input int maxv);
        return (c >= maxv) ? maxv : c + 1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_sticky = '0;
        m_inv = 0; m_huge = 0; m_tiny = 0;
        m_inv2 = 0; m_huge2 = 0; m_tiny2 = 0;
    endtask

    // Apply current inputs for one clock, advance the model, compare everything.
    task automatic step();
        bit m_acc, m_del;
        chk("in_ready_pre", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
        chk("in_ready2_pre", {63'd0, in_ready2}, {63'd0, (q.size() < 2)});
        m_acc = in_valid && (q.size() < 2);
        m_del = (q.size() != 0) && out_ready;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            model_clear();
        end else begin
            if (clr_sticky) model_clear();
            if (m_del) void'(q.pop_front());
            if (m_acc) begin
                q.push_back({in_status, in_z});
                m_sticky = m_sticky | in_status[5:0];
                if (in_status[2]) begin m_inv  = sat(m_inv, 65535);  m_inv2  = sat(m_inv2, 3);  end
                if (in_status[4]) begin m_huge = sat(m_huge, 65535); m_huge2 = sat(m_huge2, 3); end
                if (in_status[3]) begin m_tiny = sat(m_tiny, 65535); m_tiny2 = sat(m_tiny2, 3); end
            end
        end
        chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() != 0)});
        chk("out_valid2", {63'd0, out_valid2}, {63'd0, (q.size() != 0)});
        if (q.size() != 0) begin
            chk("out_word", {24'd0, out_status, out_z}, {24'd0, q[0]});
            chk("out_word2", {24'd0, out_status2, out_z2}, {24'd0, q[0]});
        end
        chk("sticky", {58'd0, sticky}, {58'd0, m_sticky});
        chk("cnt_invalid", {48'd0, cnt_invalid}, 64'(m_inv));
        chk("cnt_huge", {48'd0, cnt_huge}, 64'(m_huge));
        chk("cnt_tiny", {48'd0, cnt_tiny}, 64'(m_tiny));
        chk("cnt2_invalid", {62'd0, cnt_invalid2}, 64'(m_inv2));
        chk("cnt2_huge", {62'd0, cnt_huge2}, 64'(m_huge2));
        chk("cnt2_tiny", {62'd0, cnt_tiny2}, 64'(m_tiny2));
    endtask

    task automatic drive(input logic v, input logic [31:0] z, input logic [7:0] s,
                         input logic ordy, input logic clr);
        in_valid = v; in_z = z; in_status = s; out_ready = ordy; clr_sticky = clr;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] z;
        logic [7:0]  st;
        logic        ordy;
        logic        ov;
        logic [31:0] ez;
        logic        ir;
        logic [5:0]  es;
        int          ci, ch, ct;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 32'h40800000, 8'h00, 1'b1, 1'b1, 32'h40800000, 1'b1, 6'h00, 0, 0, 0};
        tbl[1]  = '{1'b0, 32'h00000000, 8'h00, 1'b1, 1'b0, 32'h00000000, 1'b1, 6'h00, 0, 0, 0};
        tbl[2]  = '{1'b1, 32'h11111111, 8'h00, 1'b0, 1'b1, 32'h11111111, 1'b1, 6'h00, 0, 0, 0};
        tbl[3]  = '{1'b1, 32'h22222222, 8'h00, 1'b0, 1'b1, 32'h11111111, 1'b0, 6'h00, 0, 0, 0};
        tbl[4]  = '{1'b1, 32'h33333333, 8'h00, 1'b0, 1'b1, 32'h11111111, 1'b0, 6'h00, 0, 0, 0};
        tbl[5]  = '{1'b1, 32'h33333333, 8'h00, 1'b1, 1'b1, 32'h22222222, 1'b1, 6'h00, 0, 0, 0};
        tbl[6]  = '{1'b1, 32'h33333333, 8'h00, 1'b1, 1'b1, 32'h33333333, 1'b1, 6'h00, 0, 0, 0};
        tbl[7]  = '{1'b0, 32'h00000000, 8'h00, 1'b1, 1'b0, 32'h00000000, 1'b1, 6'h00, 0, 0, 0};
        tbl[8]  = '{1'b1, 32'h7fc00000, 8'h04, 1'b1, 1'b1, 32'h7fc00000, 1'b1, 6'h04, 1, 0, 0};
        tbl[9]  = '{1'b1, 32'h7f800000, 8'h12, 1'b1, 1'b1, 32'h7f800000, 1'b1, 6'h16, 1, 1, 0};
        tbl[10] = '{1'b0, 32'h00000000, 8'h00, 1'b1, 1'b0, 32'h00000000, 1'b1, 6'h16, 1, 1, 0};

        q.delete();
        model_clear();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_z", {32'd0, out_z}, 64'd0);
        chk("rst_out_status", {56'd0, out_status}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_sticky", {58'd0, sticky}, 64'd0);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].z, tbl[i].st, tbl[i].ordy, 1'b0);
            step();
            chk($sformatf("tbl%0d_ov", i), {63'd0, out_valid}, {63'd0, tbl[i].ov});
            if (tbl[i].ov)
                chk($sformatf("tbl%0d_z", i), {32'd0, out_z}, {32'd0, tbl[i].ez});
            chk($sformatf("tbl%0d_ir", i), {63'd0, in_ready}, {63'd0, tbl[i].ir});
            chk($sformatf("tbl%0d_sticky", i), {58'd0, sticky}, {58'd0, tbl[i].es});
            chk($sformatf("tbl%0d_cinv", i), {48'd0, cnt_invalid}, 64'(tbl[i].ci));
            chk($sformatf("tbl%0d_chuge", i), {48'd0, cnt_huge}, 64'(tbl[i].ch));
            chk($sformatf("tbl%0d_ctiny", i), {48'd0, cnt_tiny}, 64'(tbl[i].ct));
        end

        // Five tiny results: the 2-bit counter must stop at 3.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h00000100 + i, 8'h08, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        step();
        chk("sat_tiny_c2", {62'd0, cnt_tiny2}, 64'd3);
        chk("sat_tiny_c16", {48'd0, cnt_tiny}, 64'd5);

        // Clear coinciding with an accept keeps only that word's flags.
        drive(1'b1, 32'h3f800000, 8'h20, 1'b1, 1'b1);
        step();
        chk("clr_sticky", {58'd0, sticky}, 64'h20);
        chk("clr_cinv", {48'd0, cnt_invalid}, 64'd0);
        chk("clr_chuge", {48'd0, cnt_huge}, 64'd0);
        chk("clr_ctiny", {48'd0, cnt_tiny}, 64'd0);
        chk("clr_ctiny2", {62'd0, cnt_tiny2}, 64'd0);
        chk("clr_keeps_data", {32'd0, out_z}, 64'h3f800000);

        // Fill the queue, then reset mid-operation.
        drive(1'b1, 32'haaaa0001, 8'h1c, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'haaaa0002, 8'h1c, 1'b0, 1'b0);
        step();
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_sticky", {58'd0, sticky}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
            step();
            chk("no_stale_out", {63'd0, out_valid}, 64'd0);
        end

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 10000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            drive(($urandom_range(0, 9) < 7), $urandom, 8'($urandom),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
            step();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
